hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. Each cycle it decides the enable (stall) and clear (flush) controls for the F->D, D->E, E->M and M->W pipeline registers and the E-stage forwarding selects. Inputs are register indices from each stage, instruction and data memory ready handshakes, and the branch-taken signal from Execute. It also tracks redirects that happen during an outstanding fetch, and raises a sticky error on a memory wait timeout.

---
 rtl/hazard_if.sv | 50 +++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: bundles the pipeline-side hazard inputs and the control
// outputs of hazard_ctrl. The slave modport is the controller's view and
// the master modport is the pipeline's view.
interface hazard_if;
  logic [4:0]  rs1_d_i;
  logic [4:0]  rs2_d_i;
  logic [4:0]  rs1_e_i;
  logic [4:0]  rs2_e_i;
  logic [4:0]  rd_e_i;
  logic        load_e_i;
  logic        pc_src_e_i;
  logic [4:0]  rd_m_i;
  logic [4:0]  rd_w_i;
  logic        reg_write_m_i;
  logic        reg_write_w_i;
  logic        imem_ready_i;
  logic        dmem_req_m_i;
  logic        dmem_ready_i;

  logic        stall_f_o;
  logic        stall_d_o;
  logic        stall_e_o;
  logic        stall_m_o;
  logic        flush_d_o;
  logic        flush_e_o;
  logic        flush_w_o;
  logic [1:0]  forward_a_e_o;
  logic [1:0]  forward_b_e_o;
  logic [1:0]  stall_cause_o;
  logic        err_o;
  logic [31:0] stall_cycles_o;

  modport slave (
    input  rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, load_e_i, pc_src_e_i,
           rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i,
           imem_ready_i, dmem_req_m_i, dmem_ready_i,
    output stall_f_o, stall_d_o, stall_e_o, stall_m_o,
           flush_d_o, flush_e_o, flush_w_o,
           forward_a_e_o, forward_b_e_o, stall_cause_o, err_o, stall_cycles_o
  );

  modport master (
    output rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, load_e_i, pc_src_e_i,
           rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i,
           imem_ready_i, dmem_req_m_i, dmem_ready_i,
    input  stall_f_o, stall_d_o, stall_e_o, stall_m_o,
           flush_d_o, flush_e_o, flush_w_o,
           forward_a_e_o, forward_b_e_o, stall_cause_o, err_o, stall_cycles_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for the 5-stage RV32I core.
// Priority: data-memory wait, then instruction-memory wait, then load-use.
// Tracks a branch redirect taken while a fetch is outstanding, and raises a
// sticky error after TIMEOUT consecutive memory-wait cycles.
// Optional macro HAZARD_PERF_EN builds a 32-bit stall-cycle counter;
// without it stall_cycles_o is tied to zero.
module hazard_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  hazard_if.slave  hz
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    CAUSE_RUN     = 2'b00,
    CAUSE_IWAIT   = 2'b01,
    CAUSE_DWAIT   = 2'b10,
    CAUSE_LOADUSE = 2'b11
  } cause_e;

  logic          w_dwait, w_iwait, w_lu;
  logic          w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic          w_flush_d, w_flush_e, w_flush_w;
  cause_e        w_cause;
  logic          w_redir_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_err_nxt;

  cause_e        r_cause;
  logic          r_redir;
  logic [CW-1:0] r_wait_cnt;
  logic          r_err;

  assign w_dwait = hz.dmem_req_m_i & ~hz.dmem_ready_i;
  assign w_iwait = ~hz.imem_ready_i;
  assign w_lu    = hz.load_e_i & (hz.rd_e_i != 5'd0) &
                   ((hz.rd_e_i == hz.rs1_d_i) | (hz.rd_e_i == hz.rs2_d_i));

  // Prioritised hazard decode into raw stall/flush controls and the cause.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_cause   = CAUSE_RUN;
    if (w_dwait) begin
      // Whole front of the pipe freezes; W gets a bubble. A taken branch
      // stays in E and is honoured once E advances.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
      w_cause   = CAUSE_DWAIT;
    end else if (w_iwait) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_d = hz.pc_src_e_i;
      w_cause   = CAUSE_IWAIT;
    end else if (w_lu) begin
      // imem is ready here, so a pending redirect discards the fetched word.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_d = hz.pc_src_e_i | r_redir;
      w_cause   = CAUSE_LOADUSE;
    end else begin
      w_flush_d = hz.pc_src_e_i | r_redir;
      w_flush_e = hz.pc_src_e_i;
    end
  end

  // Next-state for redirect tracking, wait counter and sticky error.
  always_comb begin
    w_redir_nxt = r_redir;
    if (!w_dwait) begin
      if (w_iwait && hz.pc_src_e_i) w_redir_nxt = 1'b1;
      else if (hz.imem_ready_i)     w_redir_nxt = 1'b0;
    end
    if (w_dwait || w_iwait) w_cnt_nxt = (r_wait_cnt == TMAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    else                    w_cnt_nxt = '0;
    // Error is raised on the edge that completes the TIMEOUTth wait cycle.
    w_err_nxt = r_err | (w_cnt_nxt == TMAX);
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cause    <= CAUSE_RUN;
      r_redir    <= 1'b0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cause    <= w_cause;
      r_redir    <= w_redir_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Forwarding select: M result has priority over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.reg_write_m_i && hz.rd_m_i != 5'd0 && hz.rd_m_i == rs)      return 2'b10;
    else if (hz.reg_write_w_i && hz.rd_w_i != 5'd0 && hz.rd_w_i == rs) return 2'b01;
    else                                                               return 2'b00;
  endfunction

  // During reset every stage register is bubbled and nothing stalls.
  assign hz.stall_f_o     = rst_ni & w_stall_f;
  assign hz.stall_d_o     = rst_ni & w_stall_d;
  assign hz.stall_e_o     = rst_ni & w_stall_e;
  assign hz.stall_m_o     = rst_ni & w_stall_m;
  assign hz.flush_d_o     = ~rst_ni | w_flush_d;
  assign hz.flush_e_o     = ~rst_ni | w_flush_e;
  assign hz.flush_w_o     = ~rst_ni | w_flush_w;
  assign hz.forward_a_e_o = rst_ni ? fwd_sel(hz.rs1_e_i) : 2'b00;
  assign hz.forward_b_e_o = rst_ni ? fwd_sel(hz.rs2_e_i) : 2'b00;
  assign hz.stall_cause_o = r_cause;
  assign hz.err_o         = r_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;

  // Count every cycle in which any stage is held; wraps at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                         r_stall_cycles <= '0;
    else if (w_stall_f | w_stall_d | w_stall_e | w_stall_m) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign hz.stall_cycles_o = r_stall_cycles;
`else
  assign hz.stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a rule-level model.
module tb_hazard_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  hazard_if hz ();

  hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz)
  );

  always #5 clk = ~clk;

  // Model state
  bit          m_redir;
  int unsigned m_cnt;
  bit          m_err;
  bit [1:0]    m_cause;
  bit [31:0]   m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit [1:0] m_fwd(input bit [4:0] rs);
    if (hz.reg_write_m_i && hz.rd_m_i != 0 && hz.rd_m_i == rs) return 2'd2;
    if (hz.reg_write_w_i && hz.rd_w_i != 0 && hz.rd_w_i == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Expected values of all outputs from the current inputs and model state.
  bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
  bit [1:0] e_cause_now;
  task automatic model_eval();
    bit dw, iw, lu, br;
    dw = hz.dmem_req_m_i && !hz.dmem_ready_i;
    iw = !hz.imem_ready_i;
    lu = hz.load_e_i && hz.rd_e_i != 0 &&
         (hz.rd_e_i == hz.rs1_d_i || hz.rd_e_i == hz.rs2_d_i);
    br = hz.pc_src_e_i;
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    if (dw)      begin {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111; e_cause_now = 2'd2; end
    else if (iw) begin e_sf = 1; e_sd = 1; e_fe = 1; e_fd = br; e_cause_now = 2'd1; end
    else if (lu) begin e_sf = 1; e_sd = 1; e_fe = 1; e_fd = br || m_redir; e_cause_now = 2'd3; end
    else         begin e_fe = br; e_fd = br || m_redir; e_cause_now = 2'd0; end
  endtask

  task automatic compare_all();
    if (!rst_n) begin
      m_redir = 0; m_cnt = 0; m_err = 0; m_cause = 0; m_perf = 0;
    end
    model_eval();
    if (!rst_n) begin
      check("m_stall_f", hz.stall_f_o, 0);
      check("m_stall_m", hz.stall_m_o, 0);
      check("m_flush", {hz.flush_d_o, hz.flush_e_o, hz.flush_w_o}, 3'b111);
      check("m_fwd", {hz.forward_a_e_o, hz.forward_b_e_o}, 0);
    end else begin
      check("m_stalls", {hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o},
            {e_sf, e_sd, e_se, e_sm});
      check("m_flushes", {hz.flush_d_o, hz.flush_e_o, hz.flush_w_o}, {e_fd, e_fe, e_fw});
      check("m_fwd_a", hz.forward_a_e_o, m_fwd(hz.rs1_e_i));
      check("m_fwd_b", hz.forward_b_e_o, m_fwd(hz.rs2_e_i));
    end
    check("m_cause", hz.stall_cause_o, m_cause);
    check("m_err", hz.err_o, m_err);
`ifdef HAZARD_PERF_EN
    check("m_perf", hz.stall_cycles_o, m_perf);
`else
    check("m_perf", hz.stall_cycles_o, 0);
`endif
  endtask

  task automatic model_edge();
    bit dw, iw;
    if (!rst_n) begin
      m_redir = 0; m_cnt = 0; m_err = 0; m_cause = 0; m_perf = 0;
      return;
    end
    dw = hz.dmem_req_m_i && !hz.dmem_ready_i;
    iw = !hz.imem_ready_i;
    model_eval();
    m_cause = e_cause_now;
    if (!dw) begin
      if (iw && hz.pc_src_e_i) m_redir = 1;
      else if (!iw)            m_redir = 0;
    end
    if (dw || iw) m_cnt = (m_cnt < TO) ? m_cnt + 1 : m_cnt;
    else          m_cnt = 0;
    if (m_cnt == TO) m_err = 1;
    if (e_sf || e_sd || e_se || e_sm) m_perf = m_perf + 1;
  endtask

  // One clock: compare mid-cycle, then advance model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    hz.rs1_d_i = 0; hz.rs2_d_i = 0; hz.rs1_e_i = 0; hz.rs2_e_i = 0; hz.rd_e_i = 0;
    hz.load_e_i = 0; hz.pc_src_e_i = 0; hz.rd_m_i = 0; hz.rd_w_i = 0;
    hz.reg_write_m_i = 0; hz.reg_write_w_i = 0;
    hz.imem_ready_i = 1; hz.dmem_req_m_i = 0; hz.dmem_ready_i = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    m_redir = 0; m_cnt = 0; m_err = 0; m_cause = 0; m_perf = 0;
    #1;
    // Reset outputs
    check("rst_flush", {hz.flush_d_o, hz.flush_e_o, hz.flush_w_o}, 3'b111);
    check("rst_stall", {hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o}, 4'b0000);
    check("rst_cause", hz.stall_cause_o, 2'b00);
    cycle(); cycle();
    rst_n = 1;
    cycle();

    // Load-use on rs1, then forward from M
    hz.load_e_i = 1; hz.rd_e_i = 5; hz.rs1_d_i = 5; #1;
    check("lu_ctrl", {hz.stall_f_o, hz.stall_d_o, hz.flush_e_o, hz.flush_d_o}, 4'b1110);
    cycle();
    check("lu_cause", hz.stall_cause_o, 2'b11);
    idle(); hz.rs1_e_i = 5; hz.rd_m_i = 5; hz.reg_write_m_i = 1; #1;
    check("lu_fwd_a", hz.forward_a_e_o, 2'b10);
    check("lu_nostall", hz.stall_f_o, 1'b0);
    cycle();

    // Load to x0, and x0 never forwarded
    idle(); hz.load_e_i = 1; hz.rd_e_i = 0; hz.rs2_d_i = 0;
    hz.rs2_e_i = 0; hz.rd_m_i = 0; hz.reg_write_m_i = 1; hz.reg_write_w_i = 1; #1;
    check("x0_nostall", hz.stall_f_o, 1'b0);
    check("x0_fwd_b", hz.forward_b_e_o, 2'b00);
    cycle();
    // W-only forward
    idle(); hz.rs2_e_i = 7; hz.rd_w_i = 7; hz.reg_write_w_i = 1; #1;
    check("w_fwd_b", hz.forward_b_e_o, 2'b01);
    cycle();

    // Redirect during outstanding fetch
    idle(); hz.imem_ready_i = 0; hz.pc_src_e_i = 1; #1;
    check("iw_br_flush_d", hz.flush_d_o, 1'b1);
    check("iw_stall_f", hz.stall_f_o, 1'b1);
    cycle();
    hz.pc_src_e_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1; check("iw_hold_flush_d", hz.flush_d_o, 1'b0);
      cycle();
    end
    check("iw_cause", hz.stall_cause_o, 2'b01);
    hz.imem_ready_i = 1; #1;
    check("redir_flush_d", hz.flush_d_o, 1'b1);
    cycle();
    #1; check("redir_cleared", hz.flush_d_o, 1'b0);
    cycle();

    // Data wait with a taken branch held in E
    idle(); hz.dmem_req_m_i = 1; hz.dmem_ready_i = 0; hz.pc_src_e_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("dw_ctrl", {hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o,
                        hz.flush_w_o, hz.flush_d_o, hz.flush_e_o}, 7'b1111100);
      cycle();
    end
    check("dw_cause", hz.stall_cause_o, 2'b10);
    hz.dmem_ready_i = 1; #1;
    check("dw_release", {hz.flush_d_o, hz.flush_e_o, hz.stall_f_o}, 3'b110);
    cycle();

    // Timeout: eight consecutive fetch waits
    idle(); hz.imem_ready_i = 0;
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) check("to_not_yet", hz.err_o, 1'b0);
      cycle();
    end
    check("to_err_set", hz.err_o, 1'b1);
    idle();
    cycle(); cycle();
    check("to_err_sticky", hz.err_o, 1'b1);
    rst_n = 0; #1;
    check("to_err_reset", hz.err_o, 1'b0);
    cycle();
    rst_n = 1;

    // Five mixed stall cycles, then idle
    idle(); hz.imem_ready_i = 0; cycle(); cycle();
    idle(); hz.dmem_req_m_i = 1; hz.dmem_ready_i = 0; cycle(); cycle();
    idle(); hz.load_e_i = 1; hz.rd_e_i = 3; hz.rs2_d_i = 3; cycle();
    idle(); cycle();
`ifdef HAZARD_PERF_EN
    check("perf_count", hz.stall_cycles_o, 32'd5);
`else
    check("perf_count", hz.stall_cycles_o, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      hz.rs1_d_i       = 5'($urandom_range(0, 3));
      hz.rs2_d_i       = 5'($urandom_range(0, 3));
      hz.rs1_e_i       = 5'($urandom_range(0, 3));
      hz.rs2_e_i       = 5'($urandom_range(0, 3));
      hz.rd_e_i        = 5'($urandom_range(0, 3));
      hz.rd_m_i        = 5'($urandom_range(0, 3));
      hz.rd_w_i        = 5'($urandom_range(0, 3));
      hz.load_e_i      = 1'($urandom_range(0, 1));
      hz.pc_src_e_i    = ($urandom_range(0, 3) == 0);
      hz.reg_write_m_i = 1'($urandom_range(0, 1));
      hz.reg_write_w_i = 1'($urandom_range(0, 1));
      hz.imem_ready_i  = ($urandom_range(0, 3) != 0);
      hz.dmem_req_m_i  = 1'($urandom_range(0, 1));
      hz.dmem_ready_i  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
